// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4-lite arbiter.
package axi4_lite_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } arb_state_e;

    typedef logic gnt_idx_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_interface.sv
// AXI4-lite bundle without prot/strobe sidebands; master drives requests, slave drives responses.
interface axi4_lite_interface #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned REG_DATA_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [REG_DATA_WIDTH-1:0] wdata;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      arvalid;
    logic                      arready;
    logic [REG_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_rr_arbiter.sv
// Two-requester round-robin picker; last_grant favours the other requester on contention.
module axi4_lite_rr_arbiter
    import axi4_lite_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    gnt_idx_t           last_grant_q;
    gnt_idx_t           last_grant_d;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        pick         = '0;
        last_grant_d = last_grant_q;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_grant_q ? 2'b01 : 2'b10;
            default: pick = '0;
        endcase
        gnt = en ? pick : '0;
        if (gnt != '0) begin
            last_grant_d = gnt[1];
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Shares one AXI4-lite slave between two masters, one transaction at a time,
// with a registered grant and combinational forwarding of the granted channels.
module axi4_lite_arbiter_2to1
    import axi4_lite_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned REG_DATA_WIDTH = 32
) (
    input  logic                 axi4_lite_aclk,
    input  logic                 axi4_lite_aresetn,
    axi4_lite_interface.slave    m0_if,
    axi4_lite_interface.slave    m1_if,
    axi4_lite_interface.master   s_if
);

    arb_state_e         state_q, state_d;
    gnt_idx_t           gnt_idx_q, gnt_idx_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               win_aw;

    logic                      sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [ADDRESS_WIDTH-1:0]  sel_awaddr, sel_araddr;
    logic [REG_DATA_WIDTH-1:0] sel_wdata;

    logic                      up_awready, up_wready, up_arready, up_bvalid, up_rvalid;
    logic [1:0]                up_bresp, up_rresp;
    logic [REG_DATA_WIDTH-1:0] up_rdata;

    assign req    = {m1_if.awvalid | m1_if.arvalid, m0_if.awvalid | m0_if.arvalid};
    assign win_aw = gnt[1] ? m1_if.awvalid : m0_if.awvalid;

    axi4_lite_rr_arbiter u_rr (
        .clk   (axi4_lite_aclk),
        .rst_n (axi4_lite_aresetn),
        .req   (req),
        .en    (state_q == IDLE),
        .gnt   (gnt)
    );

    // Requester-side signals of the currently granted master.
    always_comb begin
        sel_awvalid = gnt_idx_q ? m1_if.awvalid : m0_if.awvalid;
        sel_awaddr  = gnt_idx_q ? m1_if.awaddr  : m0_if.awaddr;
        sel_wvalid  = gnt_idx_q ? m1_if.wvalid  : m0_if.wvalid;
        sel_wdata   = gnt_idx_q ? m1_if.wdata   : m0_if.wdata;
        sel_bready  = gnt_idx_q ? m1_if.bready  : m0_if.bready;
        sel_arvalid = gnt_idx_q ? m1_if.arvalid : m0_if.arvalid;
        sel_araddr  = gnt_idx_q ? m1_if.araddr  : m0_if.araddr;
        sel_rready  = gnt_idx_q ? m1_if.rready  : m0_if.rready;
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        s_if.awvalid = 1'b0;
        s_if.awaddr  = '0;
        s_if.wvalid  = 1'b0;
        s_if.wdata   = '0;
        s_if.bready  = 1'b0;
        s_if.arvalid = 1'b0;
        s_if.araddr  = '0;
        s_if.rready  = 1'b0;
        up_awready = 1'b0;
        up_wready  = 1'b0;
        up_arready = 1'b0;
        up_bvalid  = 1'b0;
        up_bresp   = '0;
        up_rvalid  = 1'b0;
        up_rresp   = '0;
        up_rdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt != '0) begin
                    gnt_idx_d = gnt[1];
                    state_d   = win_aw ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                // AW and W complete independently; a finished channel stays masked.
                if (!aw_done_q) begin
                    s_if.awvalid = sel_awvalid;
                    s_if.awaddr  = sel_awaddr;
                    up_awready   = s_if.awready;
                    aw_done_d    = sel_awvalid & s_if.awready;
                end
                if (!w_done_q) begin
                    s_if.wvalid = sel_wvalid;
                    s_if.wdata  = sel_wdata;
                    up_wready   = s_if.wready;
                    w_done_d    = sel_wvalid & s_if.wready;
                end
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                s_if.bready = sel_bready;
                up_bvalid   = s_if.bvalid;
                up_bresp    = s_if.bresp;
                if (s_if.bvalid && sel_bready) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                s_if.arvalid = sel_arvalid;
                s_if.araddr  = sel_araddr;
                up_arready   = s_if.arready;
                if (sel_arvalid && s_if.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                s_if.rready = sel_rready;
                up_rvalid   = s_if.rvalid;
                up_rresp    = s_if.rresp;
                up_rdata    = s_if.rdata;
                if (s_if.rvalid && sel_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route responses only to the granted master; the other sees zeros.
    always_comb begin
        m0_if.awready = up_awready & ~gnt_idx_q;
        m0_if.wready  = up_wready  & ~gnt_idx_q;
        m0_if.arready = up_arready & ~gnt_idx_q;
        m0_if.bvalid  = up_bvalid  & ~gnt_idx_q;
        m0_if.rvalid  = up_rvalid  & ~gnt_idx_q;
        m0_if.bresp   = gnt_idx_q ? 2'b00 : up_bresp;
        m0_if.rresp   = gnt_idx_q ? 2'b00 : up_rresp;
        m0_if.rdata   = gnt_idx_q ? '0 : up_rdata;
        m1_if.awready = up_awready & gnt_idx_q;
        m1_if.wready  = up_wready  & gnt_idx_q;
        m1_if.arready = up_arready & gnt_idx_q;
        m1_if.bvalid  = up_bvalid  & gnt_idx_q;
        m1_if.rvalid  = up_rvalid  & gnt_idx_q;
        m1_if.bresp   = gnt_idx_q ? up_bresp : 2'b00;
        m1_if.rresp   = gnt_idx_q ? up_rresp : 2'b00;
        m1_if.rdata   = gnt_idx_q ? up_rdata : '0;
    end

    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) begin
            state_q   <= IDLE;
            gnt_idx_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
